// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: FSM encoding, default sizing
// and the address check used at request acceptance.
// No ports; imported by mips_mem_responder and mem_word_array.
package mips_mem_responder_pkg;

  localparam int unsigned MEM_DEPTH_DEFAULT   = 64;
  localparam int unsigned MEM_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is rejected when it is not word aligned or names a word past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Purpose: DEPTH x 32-bit word store, one synchronous write port, one asynchronous read port.
// Latency: write commits on the clock edge; read data follows raddr combinationally.
// Backpressure: none, the port is always available.
// Ports: clk/rst (async active-low, clears every word), we/waddr/wdata write port,
//        raddr/rdata read port.
module mem_word_array
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH_DEFAULT,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Every word is cleared by reset, including stores committed just before it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Purpose: single-outstanding load/store responder for a MIPS core, backed by mem_word_array.
// Latency: response valid LATENCY cycles after acceptance (1..15); one transaction at a time.
// Backpressure: response held stable until resp_ready; req_ready only while idle.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_write/req_addr/req_wdata request
//        channel; resp_valid/resp_ready/resp_rdata/resp_err response channel.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = MEM_DEPTH_DEFAULT,
  parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT ends on the edge where the incremented count reaches LATENCY-1, so RESP is entered
  // LATENCY-1 edges after acceptance and the core samples resp_valid LATENCY edges later.
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic [3:0]    cnt_nxt;

  assign accept   = req_valid && (state == IDLE);
  assign req_err  = addr_err(req_addr, DEPTH);
  assign word_idx = req_addr[AW+1:2];
  assign cnt_nxt  = cnt + 4'd1;

  // Stores commit on the acceptance edge, so a following load always sees them.
  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && req_write && !req_err),
    .waddr (word_idx),
    .wdata (req_wdata),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt     <= '0;
            err_q   <= req_err;
            rdata_q <= (req_err || req_write) ? 32'd0 : mem_rdata;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == LAT_LAST) state <= RESP;
        end
        RESP: begin
          // Outputs return to zero once the core has taken the response.
          if (resp_ready) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
